// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, legality check, FSM states.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_MUL  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOTA = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op != 3'b110) && (op != 3'b111);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: nearest asserted request at or above ptr.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  id
);

   logic [N_REQ-1:0] rot;
   logic [ID_W:0]    sum;

   always_comb begin
      rot = N_REQ'({req, req} >> ptr);
      sum = '0;
      // scan far-to-near so the closest request to ptr wins
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            sum = {1'b0, ptr} + (ID_W+1)'(j);
         end
      end
      if (sum >= (ID_W+1)'(N_REQ)) begin
         sum = sum - (ID_W+1)'(N_REQ);
      end
      id    = sum[ID_W-1:0];
      grant = (|req) ? (N_REQ'(1) << id) : '0;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between N_REQ requesters via round-robin
// arbitration and a four-state issue/capture/respond sequencer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [8*N_REQ-1:0]   req_a,
   input  logic [8*N_REQ-1:0]   req_b,
   input  logic [3*N_REQ-1:0]   req_op,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic [15:0]          resp_result,
   output logic                 resp_err,
   output logic                 alu_en,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [2:0]           alu_op,
   input  logic [15:0]          alu_result
);

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  next_ptr;
   logic [7:0]       sel_a;
   logic [7:0]       sel_b;
   logic [2:0]       sel_op;
   logic             take;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .id    (win_id)
   );

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_a  = req_a[8*i +: 8];
            sel_b  = req_b[8*i +: 8];
            sel_op = req_op[3*i +: 3];
         end
      end
   end

   // ready must stay low while reset is held, even with requests pending
   assign req_ready = (state == IDLE && rst_n) ? grant : '0;
   assign take      = |req_ready;
   assign next_ptr  = (win_id == ID_W'(N_REQ - 1)) ? '0
                                                   : win_id + ID_W'(1);

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         resp_valid  <= 1'b0;
         resp_id     <= '0;
         resp_result <= '0;
         resp_err    <= 1'b0;
         alu_en      <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  alu_a   <= sel_a;
                  alu_b   <= sel_b;
                  alu_op  <= sel_op;
                  resp_id <= win_id;
                  rr_ptr  <= next_ptr;
                  if (is_legal_op(sel_op)) begin
                     alu_en <= 1'b1;
                     state  <= ISSUE;
                  end else begin
                     resp_valid  <= 1'b1;
                     resp_err    <= 1'b1;
                     resp_result <= '0;
                     state       <= RESP;
                  end
               end
            end
            ISSUE: begin
               alu_en <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               resp_result <= alu_result;
               resp_err    <= 1'b0;
               resp_valid  <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU attached.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [11:0] req_op = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [1:0]  resp_id;
   logic [15:0] resp_result;
   logic        resp_err;
   logic        alu_en;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_result = '0;

   int checks = 0;
   int failures = 0;
   int en_count = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N_REQ(4), .ID_W(2)) dut (
      .CLK(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_result(resp_result),
      .resp_err(resp_err),
      .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_result(alu_result)
   );

   always @(posedge clk) begin
      if (alu_en) begin
         case (alu_op)
            OP_ADD:  alu_result <= {8'h00, alu_a} + {8'h00, alu_b};
            OP_MUL:  alu_result <= 16'(alu_a) * 16'(alu_b);
            OP_AND:  alu_result <= {8'h00, alu_a & alu_b};
            OP_OR:   alu_result <= {8'h00, alu_a | alu_b};
            OP_XOR:  alu_result <= {8'h00, alu_a ^ alu_b};
            OP_NOTA: alu_result <= {8'h00, ~alu_a};
            default: alu_result <= 16'h0000;
         endcase
      end
   end

   always @(posedge clk) if (alu_en) en_count++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op);
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      req_op[id*3 +: 3] = op;
   endtask

   // drives one request and waits (bounded) for its response
   task automatic run_req(input int id, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op,
                          output logic acc, output int lat,
                          output logic [1:0] rid,
                          output logic [15:0] res, output logic err);
      tick();
      set_req(id, a, b, op);
      req_valid[id] = 1'b1;
      #1;
      acc = req_ready[id];
      tick();
      req_valid[id] = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         tick();
         lat++;
      end
      rid = resp_id;
      res = resp_result;
      err = resp_err;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL rst_ready got=%b exp=0000", req_ready);
      end
      checks++;
      if ({resp_valid, resp_err, alu_en} !== 3'b000) begin
         failures++;
         $display("FAIL rst_flags got=%b exp=000",
                  {resp_valid, resp_err, alu_en});
      end
      checks++;
      if ({resp_id, resp_result} !== 18'h0) begin
         failures++;
         $display("FAIL rst_resp got=%h exp=0", {resp_id, resp_result});
      end
      checks++;
      if ({alu_a, alu_b, alu_op} !== 19'h0) begin
         failures++;
         $display("FAIL rst_alu got=%h exp=0", {alu_a, alu_b, alu_op});
      end
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      tick();
      set_req(2, 8'd200, 8'd100, OP_ADD);
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL single_ready got=%b exp=0100", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL single_ready_drop got=%b exp=0000", req_ready);
      end
      checks++;
      if ({alu_en, alu_a, alu_b, alu_op} !== {1'b1, 8'd200, 8'd100, 3'b000}) begin
         failures++;
         $display("FAIL single_issue got=%b/%0d/%0d/%b exp=1/200/100/000",
                  alu_en, alu_a, alu_b, alu_op);
      end
      tick();
      checks++;
      if ({alu_en, resp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL single_capture got=%b exp=00", {alu_en, resp_valid});
      end
      tick();
      checks++;
      if ({resp_valid, resp_id, resp_result, resp_err} !==
          {1'b1, 2'd2, 16'd300, 1'b0}) begin
         failures++;
         $display("FAIL single_resp got=%b/%0d/%0d/%b exp=1/2/300/0",
                  resp_valid, resp_id, resp_result, resp_err);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_resp_drop got=%b exp=0", resp_valid);
      end
   endtask

   task automatic test_mul_nota();
      logic acc, err;
      int lat;
      logic [1:0] rid;
      logic [15:0] res;
      run_req(0, 8'd255, 8'd255, OP_MUL, acc, lat, rid, res, err);
      checks++;
      if ({acc, rid, res, err} !== {1'b1, 2'd0, 16'd65025, 1'b0} || lat != 3) begin
         failures++;
         $display("FAIL mul got=%b/%0d/%0d/%b lat=%0d exp=1/0/65025/0 lat=3",
                  acc, rid, res, err, lat);
      end
      run_req(0, 8'h0F, 8'h33, OP_NOTA, acc, lat, rid, res, err);
      checks++;
      if ({acc, rid, res, err} !== {1'b1, 2'd0, 16'h00F0, 1'b0} || lat != 3) begin
         failures++;
         $display("FAIL nota got=%b/%0d/%h/%b lat=%0d exp=1/0/00f0/0 lat=3",
                  acc, rid, res, err, lat);
      end
   endtask

   task automatic test_round_robin();
      int gcyc[8];
      int gid[8];
      logic [1:0] rid[8];
      logic [15:0] rres[8];
      logic [15:0] exp_res[4];
      int ng = 0;
      int nr = 0;
      exp_res[0] = 16'd3;
      exp_res[1] = 16'h0055;
      exp_res[2] = 16'h00A5;
      exp_res[3] = 16'h0100;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      set_req(0, 8'd1, 8'd2, OP_ADD);
      set_req(1, 8'h50, 8'h05, OP_OR);
      set_req(2, 8'hAA, 8'h0F, OP_XOR);
      set_req(3, 8'd16, 8'd16, OP_MUL);
      req_valid = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (|req_ready && ng < 8) begin
            gcyc[ng] = c;
            gid[ng] = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) gid[ng] = i;
            ng++;
         end
         if (resp_valid && nr < 8) begin
            rid[nr] = resp_id;
            rres[nr] = resp_result;
            nr++;
         end
         tick();
      end
      req_valid = '0;
      checks++;
      if (ng != 5 || nr != 5) begin
         failures++;
         $display("FAIL rr_counts got=%0d/%0d exp=5/5", ng, nr);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (gid[i] != i % 4) begin
            failures++;
            $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, gid[i], i % 4);
         end
         if (i > 0) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] != 4) begin
               failures++;
               $display("FAIL rr_spacing[%0d] got=%0d exp=4",
                        i, gcyc[i] - gcyc[i-1]);
            end
         end
         checks++;
         if (rid[i] !== 2'(i % 4) || rres[i] !== exp_res[i % 4]) begin
            failures++;
            $display("FAIL rr_resp[%0d] got=%0d/%h exp=%0d/%h",
                     i, rid[i], rres[i], i % 4, exp_res[i % 4]);
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      resp_ready = 1'b0;
      tick();
      set_req(2, 8'd10, 8'd20, OP_ADD);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         req_valid = 4'b1011;
         #1;
         checks++;
         if ({resp_valid, resp_id, resp_result} !== {1'b1, 2'd2, 16'd30}) begin
            failures++;
            $display("FAIL bp_hold[%0d] got=%b/%0d/%0d exp=1/2/30",
                     k, resp_valid, resp_id, resp_result);
         end
         checks++;
         if ({req_ready, alu_en} !== 5'b00000) begin
            failures++;
            $display("FAIL bp_quiet[%0d] got=%b/%b exp=0000/0",
                     k, req_ready, alu_en);
         end
      end
      req_valid = '0;
      resp_ready = 1'b1;
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got=%b exp=0", resp_valid);
      end
   endtask

   task automatic test_illegal();
      logic acc, err;
      int lat;
      logic [1:0] rid;
      logic [15:0] res;
      en_count = 0;
      run_req(1, 8'd5, 8'd6, 3'b110, acc, lat, rid, res, err);
      checks++;
      if ({acc, rid, res, err} !== {1'b1, 2'd1, 16'd0, 1'b1} || lat != 1) begin
         failures++;
         $display("FAIL illegal got=%b/%0d/%0d/%b lat=%0d exp=1/1/0/1 lat=1",
                  acc, rid, res, err, lat);
      end
      checks++;
      if (en_count != 0) begin
         failures++;
         $display("FAIL illegal_alu_en got=%0d exp=0", en_count);
      end
      run_req(0, 8'hFF, 8'h0F, OP_AND, acc, lat, rid, res, err);
      checks++;
      if ({acc, rid, res, err} !== {1'b1, 2'd0, 16'h000F, 1'b0} || lat != 3) begin
         failures++;
         $display("FAIL after_illegal got=%b/%0d/%h/%b lat=%0d exp=1/0/000f/0 lat=3",
                  acc, rid, res, err, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic acc, err;
      int lat;
      logic [1:0] rid;
      logic [15:0] res;
      tick();
      set_req(1, 8'd1, 8'd1, OP_ADD);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      req_valid = 4'b1000;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_err, alu_en} !== 7'h0) begin
         failures++;
         $display("FAIL mid_rst_flags got=%b/%b/%b/%b exp=0",
                  req_ready, resp_valid, resp_err, alu_en);
      end
      checks++;
      if ({resp_id, resp_result, alu_a, alu_b, alu_op} !== 37'h0) begin
         failures++;
         $display("FAIL mid_rst_data got=%h exp=0",
                  {resp_id, resp_result, alu_a, alu_b, alu_op});
      end
      repeat (2) begin
         tick();
         checks++;
         if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_noresp got=%b exp=0", resp_valid);
         end
      end
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL mid_rst_ptr got=%b exp=0010", req_ready);
      end
      req_valid = '0;
      run_req(3, 8'hF0, 8'h3C, OP_AND, acc, lat, rid, res, err);
      checks++;
      if ({acc, rid, res, err} !== {1'b1, 2'd3, 16'h0030, 1'b0} || lat != 3) begin
         failures++;
         $display("FAIL mid_rst_after got=%b/%0d/%h/%b lat=%0d exp=1/3/0030/0 lat=3",
                  acc, rid, res, err, lat);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mul_nota();
      test_round_robin();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit reached");
   end

endmodule
